// File: rtl/bloom_query_controller.sv
// rtl/bloom_query_controller.sv - Bloom-filter membership query FSM over a read-only SRAM
module bloom_query_controller #(
  parameter int NUM_KMERS = 212,
  parameter int NUM_HASH  = 3,
  parameter int ROW_AW    = 8,
  parameter int ROW_W     = 32,
  parameter int BIT_W     = 5,
  parameter int READ_LAT  = 1,
  localparam int CNT_W    = $clog2(NUM_KMERS + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start_query,
  input  logic                       kmer_valid,
  output logic                       kmer_ready,
  input  logic [NUM_HASH*ROW_AW-1:0] hash_row,
  input  logic [NUM_HASH*BIT_W-1:0]  hash_bit,
  output logic [ROW_AW-1:0]          sram_addr,
  input  logic [ROW_W-1:0]           sram_dout,
  output logic                       CSB,
  output logic                       OEB,
  output logic                       WEB,
  output logic                       result_valid,
  input  logic                       result_ready,
  output logic                       result_present,
  output logic [CNT_W-1:0]           hit_count,
  output logic                       busy,
  output logic                       query_done
);

  localparam int HIDX_W = (NUM_HASH > 1) ? $clog2(NUM_HASH) : 1;
  localparam int WAIT_W = $clog2(READ_LAT + 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_KMER, SET_ADDR, READ_WAIT, CHECK, REPORT, DONE
  } state_t;

  state_t                     state;
  logic [NUM_HASH*ROW_AW-1:0] row_q;
  logic [NUM_HASH*BIT_W-1:0]  bit_q;
  logic [HIDX_W-1:0]          hash_idx;
  logic [CNT_W-1:0]           kmer_cnt;
  logic [WAIT_W-1:0]          wait_cnt;
  logic [ROW_AW-1:0]          cur_row;
  logic [BIT_W-1:0]           cur_bit;
  logic                       last_hash;

  assign cur_row   = row_q[32'(hash_idx)*ROW_AW +: ROW_AW];
  assign cur_bit   = bit_q[32'(hash_idx)*BIT_W +: BIT_W];
  assign last_hash = (hash_idx == HIDX_W'(NUM_HASH - 1));
  assign WEB       = 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      row_q          <= '0;
      bit_q          <= '0;
      hash_idx       <= '0;
      kmer_cnt       <= '0;
      wait_cnt       <= '0;
      sram_addr      <= '0;
      CSB            <= 1'b1;
      OEB            <= 1'b1;
      kmer_ready     <= 1'b0;
      result_valid   <= 1'b0;
      result_present <= 1'b0;
      hit_count      <= '0;
      busy           <= 1'b0;
      query_done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_query) begin
            hit_count  <= '0;
            kmer_cnt   <= '0;
            busy       <= 1'b1;
            kmer_ready <= 1'b1;
            state      <= WAIT_KMER;
          end
        end
        WAIT_KMER: begin
          if (kmer_valid) begin
            row_q      <= hash_row;
            bit_q      <= hash_bit;
            hash_idx   <= '0;
            kmer_ready <= 1'b0;
            state      <= SET_ADDR;
          end
        end
        SET_ADDR: begin
          sram_addr <= cur_row;
          CSB       <= 1'b0;
          OEB       <= 1'b0;
          wait_cnt  <= '0;
          state     <= READ_WAIT;
        end
        READ_WAIT: begin
          if (wait_cnt == WAIT_W'(READ_LAT - 1)) state <= CHECK;
          else wait_cnt <= wait_cnt + 1'b1;
        end
        CHECK: begin
          // First clear bit ends the k-mer early; remaining hashes are never read.
          if (!sram_dout[cur_bit] || last_hash) begin
            result_present <= sram_dout[cur_bit];
            result_valid   <= 1'b1;
            CSB            <= 1'b1;
            OEB            <= 1'b1;
            state          <= REPORT;
          end else begin
            hash_idx <= hash_idx + 1'b1;
            state    <= SET_ADDR;
          end
        end
        REPORT: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            hit_count    <= hit_count + CNT_W'(result_present);
            if (kmer_cnt == CNT_W'(NUM_KMERS - 1)) begin
              query_done <= 1'b1;
              state      <= DONE;
            end else begin
              kmer_cnt   <= kmer_cnt + 1'b1;
              kmer_ready <= 1'b1;
              state      <= WAIT_KMER;
            end
          end
        end
        DONE: begin
          query_done <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bloom_query_controller.sv
// tb/tb_bloom_query_controller.sv - scoreboard bench for bloom_query_controller
module tb_bloom_query_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_query;
  logic        kmer_valid;
  logic        kmer_ready;
  logic [23:0] hash_row;
  logic [14:0] hash_bit;
  logic [7:0]  sram_addr;
  logic [31:0] sram_dout;
  logic        CSB, OEB, WEB;
  logic        result_valid;
  logic        result_ready;
  logic        result_present;
  logic [7:0]  hit_count;
  logic        busy;
  logic        query_done;

  int total = 0;
  int bad = 0;
  int web_low = 0;
  logic [31:0] mem [256];
  logic        exp_q[$];
  logic [7:0]  addr_log[$];
  logic        prev_csb = 1'b1;
  logic [7:0]  prev_addr = '0;

  bloom_query_controller dut (
    .clk(clk), .reset(reset), .start_query(start_query),
    .kmer_valid(kmer_valid), .kmer_ready(kmer_ready),
    .hash_row(hash_row), .hash_bit(hash_bit),
    .sram_addr(sram_addr), .sram_dout(sram_dout),
    .CSB(CSB), .OEB(OEB), .WEB(WEB),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_present(result_present), .hit_count(hit_count),
    .busy(busy), .query_done(query_done)
  );

  always #5 clk = ~clk;

  // One-cycle synchronous SRAM read model
  always @(posedge clk) if (!CSB && !OEB) sram_dout <= mem[sram_addr];

  always @(negedge clk) begin
    if (WEB !== 1'b1) web_low++;
    if (CSB === 1'b0 && (prev_csb || sram_addr != prev_addr)) addr_log.push_back(sram_addr);
    prev_csb  = CSB;
    prev_addr = sram_addr;
  end

  task automatic pulse_start();
    @(negedge clk) start_query = 1'b1;
    @(posedge clk);
    #1 start_query = 1'b0;
  endtask

  task automatic handshake();
    @(negedge clk) result_ready = 1'b1;
    @(posedge clk);
    #1 result_ready = 1'b0;
  endtask

  task automatic do_kmer(input logic [23:0] rows, input logic [14:0] bits, input int miss_at,
                         output int lat, output logic present);
    int wc;
    for (int h = 0; h < 3; h++)
      if (miss_at < 0 || h < miss_at) mem[rows[h*8 +: 8]][bits[h*5 +: 5]] = 1'b1;
    exp_q.push_back(miss_at < 0);
    wc = 0;
    @(negedge clk);
    while (!kmer_ready && wc < 50) begin @(negedge clk); wc++; end
    if (!kmer_ready) begin
      total++; bad++;
      $display("FAIL kmer_ready_timeout got=%b want=1", kmer_ready);
    end
    hash_row = rows; hash_bit = bits; kmer_valid = 1'b1;
    addr_log.delete();
    @(posedge clk);
    #1 kmer_valid = 1'b0; hash_row = 24'($urandom); hash_bit = 15'($urandom);
    lat = 0;
    while (lat < 60) begin
      @(negedge clk);
      if (result_valid) break;
      @(posedge clk);
      lat++;
    end
    if (lat >= 60) begin
      total++; bad++;
      $display("FAIL result_valid_timeout got=%b want=1", result_valid);
    end
    present = result_present;
  endtask

  task automatic test_reset();
    reset = 1'b0; start_query = 0; kmer_valid = 0; result_ready = 0;
    hash_row = '0; hash_bit = '0;
    repeat (3) @(negedge clk);
    total++; if ({kmer_ready, result_valid, result_present, query_done, busy} !== 5'b0) begin bad++;
      $display("FAIL reset_flags got=%b want=00000", {kmer_ready, result_valid, result_present, query_done, busy}); end
    total++; if ({CSB, OEB, WEB} !== 3'b111) begin bad++;
      $display("FAIL reset_sram_ctl got=%b want=111", {CSB, OEB, WEB}); end
    total++; if (sram_addr !== 8'd0) begin bad++;
      $display("FAIL reset_addr got=%0d want=0", sram_addr); end
    total++; if (hit_count !== 8'd0) begin bad++;
      $display("FAIL reset_hit_count got=%0d want=0", hit_count); end
    reset = 1'b1;
  endtask

  task automatic test_hit();
    int lat; logic p;
    pulse_start();
    total++; if ({busy, kmer_ready} !== 2'b11) begin bad++;
      $display("FAIL start_busy_ready got=%b want=11", {busy, kmer_ready}); end
    do_kmer({8'd17, 8'd9, 8'd5}, {5'd7, 5'd31, 5'd0}, -1, lat, p);
    total++; if (lat !== 9) begin bad++; $display("FAIL hit_latency got=%0d want=9", lat); end
    total++; if (addr_log.size() !== 3) begin bad++;
      $display("FAIL hit_reads got=%0d want=3", addr_log.size()); end
    else begin
      total++; if ({addr_log[0], addr_log[1], addr_log[2]} !== {8'd5, 8'd9, 8'd17}) begin bad++;
        $display("FAIL hit_order got=%0d,%0d,%0d want=5,9,17", addr_log[0], addr_log[1], addr_log[2]); end
    end
    total++; if (p !== exp_q.pop_front()) begin bad++; $display("FAIL hit_present got=%b want=1", p); end
    handshake();
    total++; if (hit_count !== 8'd1) begin bad++; $display("FAIL hit_count1 got=%0d want=1", hit_count); end
  endtask

  task automatic test_miss();
    int lat; logic p;
    mem[5][0] = 1'b0;
    do_kmer({8'd17, 8'd9, 8'd5}, {5'd7, 5'd31, 5'd0}, 0, lat, p);
    total++; if (lat !== 3) begin bad++; $display("FAIL miss_latency got=%0d want=3", lat); end
    total++; if (addr_log.size() !== 1 || addr_log[0] !== 8'd5) begin bad++;
      $display("FAIL miss_reads got=%0d reads want=1 read of row 5", addr_log.size()); end
    total++; if (p !== exp_q.pop_front()) begin bad++; $display("FAIL miss_present got=%b want=0", p); end
    handshake();
    total++; if (hit_count !== 8'd1) begin bad++; $display("FAIL miss_count got=%0d want=1", hit_count); end
    mem[5][0] = 1'b1;
  endtask

  task automatic test_backpressure();
    int lat; logic p; logic e;
    do_kmer({8'd10, 8'd20, 8'd30}, {5'd3, 5'd14, 5'd29}, -1, lat, p);
    total++; if (lat !== 9) begin bad++; $display("FAIL bp_latency got=%0d want=9", lat); end
    e = exp_q.pop_front();
    repeat (5) begin
      @(negedge clk);
      total++; if ({result_valid, result_present, kmer_ready, CSB} !== {1'b1, e, 1'b0, 1'b1}) begin bad++;
        $display("FAIL bp_hold got=%b want=%b", {result_valid, result_present, kmer_ready, CSB},
                 {1'b1, e, 1'b0, 1'b1}); end
    end
    handshake();
    total++; if (hit_count !== 8'd2) begin bad++; $display("FAIL bp_count got=%0d want=2", hit_count); end
  endtask

  task automatic test_full_run();
    int lat, miss_at, reads; logic p;
    logic [23:0] rows; logic [14:0] bits;
    for (int i = 3; i < 212; i++) begin
      miss_at = (i % 2 == 0) ? -1 : int'($urandom_range(0, 2));
      for (int h = 0; h < 3; h++)
        rows[h*8 +: 8] = (h == miss_at) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 65) + h * 66);
      bits = 15'($urandom);
      reads = (miss_at < 0) ? 3 : miss_at + 1;
      do_kmer(rows, bits, miss_at, lat, p);
      total++; if (lat !== 3 * reads || addr_log.size() !== reads) begin bad++;
        $display("FAIL run_kmer%0d latency=%0d reads=%0d want latency=%0d reads=%0d",
                 i, lat, addr_log.size(), 3 * reads, reads); end
      total++; if (p !== exp_q.pop_front()) begin bad++;
        $display("FAIL run_present%0d got=%b want=%b", i, p, miss_at < 0); end
      handshake();
    end
    @(negedge clk);
    total++; if ({query_done, busy} !== 2'b11) begin bad++;
      $display("FAIL done_pulse got=%b want=11", {query_done, busy}); end
    total++; if (hit_count !== 8'd106) begin bad++; $display("FAIL run_hits got=%0d want=106", hit_count); end
    @(negedge clk);
    total++; if ({query_done, busy, kmer_ready} !== 3'b000) begin bad++;
      $display("FAIL after_done got=%b want=000", {query_done, busy, kmer_ready}); end
    total++; if (hit_count !== 8'd106) begin bad++; $display("FAIL hits_hold got=%0d want=106", hit_count); end
  endtask

  task automatic test_reset_mid();
    int wc; int lat; logic p;
    pulse_start();
    wc = 0;
    while (!kmer_ready && wc < 20) begin @(negedge clk); wc++; end
    @(negedge clk) begin hash_row = {8'd3, 8'd2, 8'd1}; hash_bit = '0; kmer_valid = 1'b1; end
    @(posedge clk);
    #1 kmer_valid = 1'b0;
    @(posedge clk);
    #1;
    total++; if (CSB !== 1'b0) begin bad++; $display("FAIL mid_csb_active got=%b want=0", CSB); end
    #2 reset = 1'b0;
    #1;
    total++; if ({CSB, OEB, result_valid, busy} !== 4'b1100) begin bad++;
      $display("FAIL mid_reset got=%b want=1100", {CSB, OEB, result_valid, busy}); end
    @(negedge clk) reset = 1'b1;
    repeat (4) @(negedge clk);
    total++; if ({busy, result_valid, kmer_ready, hit_count} !== {3'b000, 8'd0}) begin bad++;
      $display("FAIL mid_idle got busy/valid/ready=%b hits=%0d want 000/0",
               {busy, result_valid, kmer_ready}, hit_count); end
    pulse_start();
    total++; if ({busy, hit_count} !== {1'b1, 8'd0}) begin bad++;
      $display("FAIL rerun_start got busy=%b hits=%0d want 1/0", busy, hit_count); end
    do_kmer({8'd50, 8'd40, 8'd60}, {5'd1, 5'd2, 5'd3}, -1, lat, p);
    total++; if (p !== exp_q.pop_front()) begin bad++; $display("FAIL rerun_present got=%b want=1", p); end
    handshake();
    total++; if (hit_count !== 8'd1) begin bad++; $display("FAIL rerun_count got=%0d want=1", hit_count); end
  endtask

  task automatic test_web();
    total++; if (web_low !== 0) begin bad++; $display("FAIL web_constant got=%0d low cycles want=0", web_low); end
  endtask

  initial begin
    for (int r = 0; r < 256; r++) mem[r] = '0;
    test_reset();
    test_hit();
    test_miss();
    test_backpressure();
    test_full_run();
    test_reset_mid();
    test_web();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
